// File: rtl/aurora_20g_adc_pgen.sv
// Test-pattern source for the ADC-path checker over the 20G Aurora link.
// Emits 8 x 16-bit lane words {b+3..b, b+3..b}, each repeated for 4 accepted beats, in shaped bursts.
module aurora_20g_adc_pgen #(
    parameter int DATA_WD = 128,
    parameter int CNT_WD  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_rst,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    input  logic [CNT_WD-1:0]  cfg_burst_len,
    input  logic [CNT_WD-1:0]  cfg_gap_len,
    input  logic [CNT_WD-1:0]  cfg_burst_num,
    input  logic               cfg_err_inj,
    input  logic               adc_rdy,
    output logic               adc_vld,
    output logic [DATA_WD-1:0] adc_data,
    output logic               busy,
    output logic               done,
    output logic [31:0]        tx_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic [15:0]         base;
    logic [1:0]          idx;
    logic                inj_lat;
    logic                stop_lat;
    logic [CNT_WD-1:0]   beat_cnt;
    logic [CNT_WD-1:0]   gap_cnt;
    logic [CNT_WD-1:0]   burst_cnt;
    logic [CNT_WD-1:0]   len_q;
    logic [CNT_WD-1:0]   gap_q;
    logic [CNT_WD-1:0]   num_q;

    logic                accept;
    logic                stop_req;
    logic                inj_any;
    logic [15:0]         base_adv;
    logic [CNT_WD-1:0]   beat_inc;
    logic [CNT_WD-1:0]   gap_inc;
    logic [CNT_WD-1:0]   burst_inc;
    logic [DATA_WD-1:0]  nxt_word;

    function automatic logic [DATA_WD-1:0] make_word(input logic [15:0] b, input logic flip);
        logic [DATA_WD-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w[16*k +: 16] = b + 16'(k % 4);
        end
        w[0] = w[0] ^ flip;
        return w;
    endfunction

    // The injected error is bound to a beat only when that beat is loaded, so a
    // stalled word never changes and pulses during a stall collapse into one error.
    always_comb begin
        accept    = adc_vld & adc_rdy;
        stop_req  = stop_lat | cfg_stop;
        inj_any   = inj_lat | cfg_err_inj;
        base_adv  = (accept && idx == 2'd3) ? base + 16'd4 : base;
        beat_inc  = beat_cnt + 1'b1;
        gap_inc   = gap_cnt + 1'b1;
        burst_inc = burst_cnt + 1'b1;
        nxt_word  = make_word(base_adv, inj_any);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cfg_rst) begin
            state     <= S_IDLE;
            adc_vld   <= 1'b0;
            adc_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_cnt    <= '0;
            base      <= '0;
            idx       <= '0;
            inj_lat   <= 1'b0;
            stop_lat  <= 1'b0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            burst_cnt <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            num_q     <= '0;
        end else begin
            if (accept) begin
                tx_cnt <= tx_cnt + 32'd1;
                idx    <= idx + 2'd1;
                base   <= base_adv;
            end
            inj_lat <= inj_any;

            case (state)
                S_IDLE, S_DONE: begin
                    stop_lat <= 1'b0;
                    if (cfg_start) begin
                        state     <= S_BURST;
                        adc_vld   <= 1'b1;
                        adc_data  <= nxt_word;
                        inj_lat   <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        burst_cnt <= '0;
                        beat_cnt  <= '0;
                        len_q     <= cfg_burst_len;
                        gap_q     <= cfg_gap_len;
                        num_q     <= cfg_burst_num;
                    end
                end

                S_BURST: begin
                    if (cfg_stop) stop_lat <= 1'b1;
                    if (accept) begin
                        beat_cnt <= beat_inc;
                        if (stop_req) begin
                            state    <= S_IDLE;
                            adc_vld  <= 1'b0;
                            busy     <= 1'b0;
                            stop_lat <= 1'b0;
                        end else if (len_q != '0 && beat_inc == len_q) begin
                            burst_cnt <= burst_inc;
                            beat_cnt  <= '0;
                            if (num_q != '0 && burst_inc == num_q) begin
                                state   <= S_DONE;
                                adc_vld <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else if (gap_q != '0) begin
                                state   <= S_GAP;
                                adc_vld <= 1'b0;
                                gap_cnt <= '0;
                            end else begin
                                adc_data <= nxt_word;
                                inj_lat  <= 1'b0;
                                len_q    <= cfg_burst_len;
                                gap_q    <= cfg_gap_len;
                            end
                        end else begin
                            adc_data <= nxt_word;
                            inj_lat  <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    if (stop_req) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        stop_lat <= 1'b0;
                    end else if (gap_inc == gap_q) begin
                        state    <= S_BURST;
                        adc_vld  <= 1'b1;
                        adc_data <= nxt_word;
                        inj_lat  <= 1'b0;
                        gap_cnt  <= '0;
                        len_q    <= cfg_burst_len;
                        gap_q    <= cfg_gap_len;
                    end else begin
                        gap_cnt <= gap_inc;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_20g_adc_pgen.sv
// Directed bench for aurora_20g_adc_pgen: a vector table for burst/gap runs plus
// hand-written sequences for backpressure, stop, error injection, clear and base wrap.
module tb_aurora_20g_adc_pgen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_rst;
    logic         cfg_start;
    logic         cfg_stop;
    logic [15:0]  cfg_burst_len;
    logic [15:0]  cfg_gap_len;
    logic [15:0]  cfg_burst_num;
    logic         cfg_err_inj;
    logic         adc_rdy;
    logic         adc_vld;
    logic [127:0] adc_data;
    logic         busy;
    logic         done;
    logic [31:0]  tx_cnt;

    aurora_20g_adc_pgen #(.DATA_WD(128), .CNT_WD(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .cfg_burst_len(cfg_burst_len), .cfg_gap_len(cfg_gap_len),
        .cfg_burst_num(cfg_burst_num), .cfg_err_inj(cfg_err_inj), .adc_rdy(adc_rdy),
        .adc_vld(adc_vld), .adc_data(adc_data), .busy(busy), .done(done), .tx_cnt(tx_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] len;
        logic [15:0] gap;
        logic [15:0] num;
        logic        exp_vld;
        logic        exp_busy;
        logic        exp_done;
        logic [15:0] exp_base;
        logic [31:0] exp_tx;
    } vec_t;

    vec_t vecs[22];

    int n_tests = 0;
    int n_fail  = 0;

    // Checker-side model of the pattern stream.
    logic [15:0]  eb;
    logic [1:0]   eidx;
    int           n_acc;
    int           n_err;
    int           n_bad;
    logic         prev_stall;
    logic [127:0] prev_data;

    function automatic vec_t mk(input logic s, input int l, input int g, input int n,
                                input logic v, input logic bz, input logic d,
                                input int b, input int t);
        vec_t r;
        r.start = s; r.len = 16'(l); r.gap = 16'(g); r.num = 16'(n);
        r.exp_vld = v; r.exp_busy = bz; r.exp_done = d;
        r.exp_base = 16'(b); r.exp_tx = 32'(t);
        return r;
    endfunction

    function automatic logic [127:0] pat(input logic [15:0] b);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = b + 16'(k % 4);
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic model_clear();
        eb = '0; eidx = '0; n_acc = 0; n_err = 0; n_bad = 0;
        prev_stall = 1'b0; prev_data = '0;
    endtask

    // One clock with the checker model watching the handshake.
    task automatic cycle(input logic r, input logic inj);
        logic [127:0] diff;
        adc_rdy = r;
        cfg_err_inj = inj;
        if (prev_stall) begin
            chk("hold_vld", 128'(adc_vld), 128'd1);
            chk("hold_data", adc_data, prev_data);
        end
        if (adc_vld && r) begin
            diff = adc_data ^ pat(eb);
            if (diff == 128'd1) n_err++;
            else if (diff != '0) n_bad++;
            n_acc++;
            eidx = eidx + 2'd1;
            if (eidx == 2'd0) eb = eb + 16'd4;
        end
        prev_stall = adc_vld && !r;
        prev_data  = adc_data;
        step();
        cfg_err_inj = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
        cfg_burst_len = '0; cfg_gap_len = '0; cfg_burst_num = '0;
        cfg_err_inj = 1'b0; adc_rdy = 1'b1;

        // start, len, gap, num, vld, busy, done, base, tx
        vecs[0]  = mk(1, 8, 0, 1, 1, 1, 0, 0, 0);
        vecs[1]  = mk(0, 8, 0, 1, 1, 1, 0, 0, 1);
        vecs[2]  = mk(0, 8, 0, 1, 1, 1, 0, 0, 2);
        vecs[3]  = mk(0, 8, 0, 1, 1, 1, 0, 0, 3);
        vecs[4]  = mk(0, 8, 0, 1, 1, 1, 0, 4, 4);
        vecs[5]  = mk(0, 8, 0, 1, 1, 1, 0, 4, 5);
        vecs[6]  = mk(0, 8, 0, 1, 1, 1, 0, 4, 6);
        vecs[7]  = mk(0, 8, 0, 1, 1, 1, 0, 4, 7);
        vecs[8]  = mk(0, 8, 0, 1, 0, 0, 1, 0, 8);
        vecs[9]  = mk(0, 8, 0, 1, 0, 0, 1, 0, 8);
        vecs[10] = mk(1, 4, 3, 2, 1, 1, 0, 8, 8);
        vecs[11] = mk(0, 4, 3, 2, 1, 1, 0, 8, 9);
        vecs[12] = mk(0, 4, 3, 2, 1, 1, 0, 8, 10);
        vecs[13] = mk(0, 4, 3, 2, 1, 1, 0, 8, 11);
        vecs[14] = mk(0, 4, 3, 2, 0, 1, 0, 0, 12);
        vecs[15] = mk(0, 4, 3, 2, 0, 1, 0, 0, 12);
        vecs[16] = mk(0, 4, 3, 2, 0, 1, 0, 0, 12);
        vecs[17] = mk(0, 4, 3, 2, 1, 1, 0, 12, 12);
        vecs[18] = mk(0, 4, 3, 2, 1, 1, 0, 12, 13);
        vecs[19] = mk(0, 4, 3, 2, 1, 1, 0, 12, 14);
        vecs[20] = mk(0, 4, 3, 2, 1, 1, 0, 12, 15);
        vecs[21] = mk(0, 4, 3, 2, 0, 0, 1, 0, 16);

        do_reset();
        chk("rst_vld", 128'(adc_vld), 128'd0);
        chk("rst_data", adc_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_tx", 128'(tx_cnt), 128'd0);

        for (int i = 0; i < 22; i++) begin
            cfg_start = vecs[i].start;
            cfg_burst_len = vecs[i].len;
            cfg_gap_len = vecs[i].gap;
            cfg_burst_num = vecs[i].num;
            adc_rdy = 1'b1;
            step();
            cfg_start = 1'b0;
            chk($sformatf("vec%0d_vld", i), 128'(adc_vld), 128'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 128'(done), 128'(vecs[i].exp_done));
            chk($sformatf("vec%0d_tx", i), 128'(tx_cnt), 128'(vecs[i].exp_tx));
            if (vecs[i].exp_vld)
                chk($sformatf("vec%0d_data", i), adc_data, pat(vecs[i].exp_base));
        end

        // Backpressure on a continuous run: rdy = 1,0,0,1,...
        do_reset();
        model_clear();
        cfg_burst_len = '0; cfg_gap_len = '0; cfg_burst_num = '0;
        cfg_start = 1'b1; adc_rdy = 1'b0;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 24; i++) cycle((i % 4 == 0) || (i % 4 == 3), 1'b0);
        chk("bp_bad", 128'(n_bad), 128'd0);
        chk("bp_err", 128'(n_err), 128'd0);
        chk("bp_acc", 128'(n_acc), 128'd12);
        chk("bp_tx", 128'(tx_cnt), 128'(n_acc));

        // Stop while stalled: beat is still owed, IDLE after it is accepted.
        adc_rdy = 1'b0; cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        chk("stop_hold_vld", 128'(adc_vld), 128'd1);
        chk("stop_hold_busy", 128'(busy), 128'd1);
        step();
        chk("stop_hold_vld2", 128'(adc_vld), 128'd1);
        prev_stall = 1'b0;
        cycle(1'b1, 1'b0);
        chk("stop_idle_vld", 128'(adc_vld), 128'd0);
        chk("stop_idle_busy", 128'(busy), 128'd0);
        chk("stop_idle_done", 128'(done), 128'd0);
        step();
        chk("stop_idle_vld2", 128'(adc_vld), 128'd0);
        chk("stop_tx", 128'(tx_cnt), 128'(n_acc));

        // Start and stop together in IDLE: start wins, stop is discarded.
        cfg_start = 1'b1; cfg_stop = 1'b1;
        step();
        cfg_start = 1'b0; cfg_stop = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        chk("startstop_busy", 128'(busy), 128'd1);
        chk("startstop_vld", 128'(adc_vld), 128'd1);
        chk("startstop_bad", 128'(n_bad), 128'd0);

        // Error injection: one pulse while flowing, two pulses during a stall.
        n_err = 0; n_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) chk("err_single", 128'(n_err), 128'd1);
            cycle(!(i >= 10 && i < 14), (i == 5) || (i == 11) || (i == 12));
        end
        chk("err_total", 128'(n_err), 128'd2);
        chk("err_bad", 128'(n_bad), 128'd0);

        // Soft clear mid-burst, then a full base wrap.
        cfg_rst = 1'b1;
        step();
        cfg_rst = 1'b0;
        chk("clr_vld", 128'(adc_vld), 128'd0);
        chk("clr_tx", 128'(tx_cnt), 128'd0);
        chk("clr_data", adc_data, 128'd0);
        chk("clr_busy", 128'(busy), 128'd0);
        model_clear();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("clr_restart", adc_data, 128'h0003_0002_0001_0000_0003_0002_0001_0000);
        for (int i = 0; i < 65540; i++) begin
            if (adc_vld && eb == 16'hFFFC && eidx == 2'd0)
                chk("wrap_fffc", adc_data, 128'hFFFF_FFFE_FFFD_FFFC_FFFF_FFFE_FFFD_FFFC);
            if (adc_vld && n_acc == 65536)
                chk("wrap_zero", adc_data, 128'h0003_0002_0001_0000_0003_0002_0001_0000);
            cycle(1'b1, 1'b0);
        end
        chk("wrap_bad", 128'(n_bad), 128'd0);
        chk("wrap_err", 128'(n_err), 128'd0);
        chk("wrap_tx", 128'(tx_cnt), 128'd65540);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aurora_20g_adc_pgen.md
Name: aurora_20g_adc_pgen

Overview:
- Test-pattern source that drives the ADC-path checker over the 20G Aurora link.
- Emits 128-bit words as 8 x 16-bit lanes: {b+3,b+2,b+1,b,b+3,b+2,b+1,b}.
- Each word is repeated for 4 accepted beats, then the base b advances by 4.
- Traffic is shaped in bursts and gaps, with valid/ready backpressure from the Aurora TX FIFO. A single-beat error can be injected to exercise the checker's err_cnt path.

Parameters:
- DATA_WD, 128, output data width; fixed at 8 lanes x 16 bits; other values unsupported.
- CNT_WD, 16, width of burst-length, gap-length and burst-count config fields.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_rst  input  1  synchronous soft clear; same effect as rst_n.
- cfg_start  input  1  one-cycle start pulse; honoured only in IDLE or DONE.
- cfg_stop  input  1  one-cycle stop request.
- cfg_burst_len  input  CNT_WD  beats per burst; 0 = continuous, no gaps.
- cfg_gap_len  input  CNT_WD  idle cycles between bursts; 0 = back-to-back.
- cfg_burst_num  input  CNT_WD  bursts per run; 0 = unlimited.
- cfg_err_inj  input  1  one-cycle pulse; corrupts one later beat.
- adc_rdy  input  1  downstream ready.
- adc_vld  output  1  data valid.
- adc_data  output  DATA_WD  pattern word.
- busy  output  1  high in BURST or GAP.
- done  output  1  high in DONE.
- tx_cnt  output  32  count of accepted beats.

Behaviour:
- Reset and clear
  - Synchronous only: on rst_n=0 or cfg_rst=1 at a clk edge, all state clears. rst_n has priority over cfg_rst.
  - Post-reset values: state=IDLE, adc_vld=0, adc_data=0, busy=0, done=0, tx_cnt=0, b=0, beat index=0, inject latch=0, burst/gap counters=0.
  - Reset mid-burst drops adc_vld the next cycle. No handshake completion is owed.
- Accept: accept = adc_vld & adc_rdy. All outputs are registered.
- Handshake
  - While adc_vld=1 and adc_rdy=0, adc_vld and adc_data hold stable.
  - adc_vld never drops without an accept, except on reset/clear.
- Pattern
  - 2-bit beat index increments per accept and wraps 3->0.
  - When index wraps, b <= b+4 (mod 2^16).
  - Lane values are b+k mod 2^16, so lanes wrap independently: at b=0xFFFE, lanes are {0x0001,0x0000,0xFFFF,0xFFFE,...}.
  - Pattern state persists across stop/start; only reset/clear zero it.
- FSM states: IDLE, BURST, GAP, DONE.
  - IDLE: cfg_start moves to BURST; adc_vld=1 on the cycle after the pulse.
  - BURST: adc_vld=1. Burst-beat counter increments per accept.
  - On the accept of beat cfg_burst_len (when len≠0), burst count increments. Next state, in priority order:
    - DONE if cfg_burst_num≠0 and count==cfg_burst_num;
    - else GAP if cfg_gap_len≠0;
    - else stay in BURST with the beat counter reset.
  - GAP: adc_vld=0 for exactly cfg_gap_len cycles, then BURST.
  - DONE: done=1, adc_vld=0. cfg_start restarts a new run (burst count=0) and clears done.
- Stop
  - cfg_stop is latched.
  - In BURST it takes effect at the next accept, giving IDLE after that beat. The pending beat is never abandoned.
  - In GAP: immediate move to IDLE.
  - In IDLE/DONE: ignored.
- Simultaneous events
  - cfg_start and cfg_stop in the same cycle in IDLE: start wins; the stop is discarded.
  - The cfg_burst_len=0 burst never ends; only stop or reset exits.
- Config sampling: cfg_* lengths are sampled at start and at each burst boundary. Changes mid-burst affect only the next burst.
- Error injection
  - cfg_err_inj sets a latch.
  - On the next accepted beat (latch=1 while adc_vld=1), adc_data bit 0 is inverted for that beat only.
  - The latch clears on accept; the pattern sequence is unaffected.
  - Multiple pulses before an accept collapse to one error.
- tx_cnt: +1 per accept, wraps at 2^32.

Test Plan:
- Basic run: reset; burst_len=8, gap_len=0, burst_num=1, rdy=1; start -> 8 beats. Beats 0-3 carry b=0; beats 4-7 carry lane0=4, lane3=7. Then done=1, tx_cnt=8.
- Gap timing: burst_len=4, gap_len=3, burst_num=2 -> 4 vld, 3 idle, 4 vld, then DONE. Second burst lane0=4.
- Backpressure: rdy toggles 1,0,0,1,... during a burst -> adc_data held while rdy=0. Checker-equivalent model sees no errors; tx_cnt equals the number of rdy-high beats.
- Error injection: pulse cfg_err_inj during continuous run with rdy=1 -> exactly one beat has bit 0 flipped. A downstream checker reports err_cnt=1, and all other beats pass.
- Stop/reset: cfg_stop with rdy=0 -> vld holds until rdy, then IDLE. cfg_rst mid-burst -> vld=0, tx_cnt=0 next cycle; restart begins at b=0.
- Wrap: run 65536 beats -> b wraps 0xFFFC -> 0x0000 with no lane mismatch.
